pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage core pipeline.
- Collects hold requests from IF (instruction bus wait), ID (load-use), EX (multi-cycle divide) and MEM (data bus wait).
- Produces one hold vector consumed by every pipeline register: PC, IF/ID, ID/EX, EX/MEM.
- Owns the divide cycle counter and the one-cycle exception/ERET flush with redirect PC.

---
 rtl/pipe_stall_ctrl_pkg.sv | 38 +++
 rtl/pipe_stall_ctrl_div_cycle_counter.sv | 30 +++
 rtl/pipe_stall_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: stall-vector
// bit positions, FSM state encoding, default exception vector and PC width.
// The PC bus width can be overridden globally via the PIPE_PC_W macro.
`ifndef PIPE_PC_W
`define PIPE_PC_W 32
`endif

package pipe_stall_ctrl_pkg;

    localparam int PC_W    = `PIPE_PC_W;
    localparam int STALL_W = 4;

    // Bit positions in the hold vector, ordered front-end to back-end
    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;

    localparam logic [PC_W-1:0] EXC_VEC_DEFAULT = 32'hBFC00380;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DIV   = 2'd1,
        ST_FLUSH = 2'd2
    } stall_state_e;

    // A stage that holds must also hold every register upstream of it, so a
    // request from stage 'idx' sets all bits from PC up to and including idx.
    function automatic logic [STALL_W-1:0] hold_upto(input int idx);
        logic [STALL_W-1:0] m;
        m = '0;
        for (int i = 0; i < STALL_W; i++) begin
            m[i] = (i <= idx);
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_div_cycle_counter.sv
// Down-counter used to time multi-cycle EX operations (divide today,
// potentially multiply later). Load has priority over decrement; the count
// parks at zero and 'zero' flags the final cycle of the operation.
module div_cycle_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load a fresh cycle budget or count down while the operation advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges hold requests from IF/ID/EX/MEM into one hold vector, sequences
// multi-cycle divides and issues a one-cycle flush with redirect PC on
// exception or ERET.
// Optional: define PIPE_PERF_CNT_EN to add a saturating stall-cycle counter.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int              DIV_CYCLES = 32,
    parameter logic [PC_W-1:0] EXC_VEC    = EXC_VEC_DEFAULT,
    parameter int              PERF_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_stall_req,
    input  logic                id_stall_req,
    input  logic                ex_div_start,
    input  logic                mem_stall_req,
    input  logic                exc_valid,
    input  logic                exc_eret,
    input  logic [PC_W-1:0]     cp0_epc,
    output logic [STALL_W-1:0]  stall,
    output logic                flush,
    output logic [PC_W-1:0]     new_pc,
    output logic                div_busy,
    output logic                div_done,
    output logic [PERF_W-1:0]   stall_cycles
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    stall_state_e    state_q;
    stall_state_e    state_d;
    logic            cnt_load;
    logic            cnt_en;
    logic            cnt_zero;
    logic            exc_take;
    logic [PC_W-1:0] new_pc_q;

    // A divide only starts from RUN and only if no exception claims the cycle.
    // The count freezes while MEM holds the whole pipe.
    assign cnt_load = (state_q == ST_RUN) && ex_div_start && !exc_valid;
    assign cnt_en   = (state_q == ST_DIV) && !mem_stall_req;

    // Exceptions are accepted in RUN and DIV, even under a MEM stall
    assign exc_take = exc_valid && (state_q != ST_FLUSH);

    div_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_div_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .load     (cnt_load),
        .load_val (DIV_LOAD),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and divide/flush status decode
    always_comb begin
        state_d  = state_q;
        div_busy = 1'b0;
        div_done = 1'b0;
        flush    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (exc_valid) begin
                    state_d = ST_FLUSH;
                end else if (ex_div_start) begin
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                div_busy = 1'b1;
                if (exc_valid) begin
                    // Aborted divide never reports completion
                    state_d = ST_FLUSH;
                end else if (cnt_zero && !mem_stall_req) begin
                    div_done = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush   = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Hold vector: the furthest-downstream requester decides how much is held
    always_comb begin
        stall = '0;
        if (state_q == ST_FLUSH) begin
            stall = '0;
        end else if (mem_stall_req) begin
            stall = hold_upto(STALL_EXMEM);
        end else if ((state_q == ST_DIV) && !div_done) begin
            stall = hold_upto(STALL_IDEX);
        end else if (id_stall_req) begin
            stall = hold_upto(STALL_IFID);
        end else if (if_stall_req) begin
            stall = hold_upto(STALL_PC);
        end
    end

    // Capture the redirect target when the exception is accepted so it is
    // stable during the following flush cycle regardless of cp0_epc
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            new_pc_q <= '0;
        end else if (exc_take) begin
            new_pc_q <= exc_eret ? cp0_epc : EXC_VEC;
        end
    end

    assign new_pc = new_pc_q;

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] perf_q;

    // Count cycles in which the PC is held, saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (stall[STALL_PC] && (perf_q != '1)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (default parameters).
// Inputs change on the falling clock edge; outputs are sampled 1ns later.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        if_stall_req;
    logic        id_stall_req;
    logic        ex_div_start;
    logic        mem_stall_req;
    logic        exc_valid;
    logic        exc_eret;
    logic [31:0] cp0_epc;
    logic [3:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_busy;
    logic        div_done;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .if_stall_req  (if_stall_req),
        .id_stall_req  (id_stall_req),
        .ex_div_start  (ex_div_start),
        .mem_stall_req (mem_stall_req),
        .exc_valid     (exc_valid),
        .exc_eret      (exc_eret),
        .cp0_epc       (cp0_epc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .div_busy      (div_busy),
        .div_done      (div_done),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  exp_stall;
        logic        mem_k;
        logic [31:0] exp_perf;

        // Reset asserted with every request active
        rst = 1'b0;
        if_stall_req = 1'b1;
        id_stall_req = 1'b1;
        ex_div_start = 1'b1;
        mem_stall_req = 1'b1;
        exc_valid = 1'b1;
        exc_eret = 1'b1;
        cp0_epc = 32'h1234_5678;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_new_pc", new_pc, 32'd0);
        chk("rst_div_busy", {31'd0, div_busy}, 32'd0);
        chk("rst_div_done", {31'd0, div_done}, 32'd0);
        chk("rst_perf", stall_cycles, 32'd0);

        // Release reset with requests low
        @(negedge clk);
        rst = 1'b1;
        if_stall_req = 1'b0;
        id_stall_req = 1'b0;
        ex_div_start = 1'b0;
        mem_stall_req = 1'b0;
        exc_valid = 1'b0;
        exc_eret = 1'b0;
        cp0_epc = 32'h0;
        #1;
        chk("idle_stall", {28'd0, stall}, 32'd0);
        chk("idle_flush", {31'd0, flush}, 32'd0);
        chk("idle_busy", {31'd0, div_busy}, 32'd0);
        @(negedge clk);
        #1;
        chk("idle2_stall", {28'd0, stall}, 32'd0);
        chk("idle2_new_pc", new_pc, 32'd0);

        // Plain divide: 31 held cycles, done on the 32nd
        @(negedge clk);
        ex_div_start = 1'b1;
        #1;
        chk("div_issue_stall", {28'd0, stall}, 32'd0);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            ex_div_start = 1'b0;
            #1;
            chk("div_hold_stall", {28'd0, stall}, 32'h7);
            chk("div_hold_done", {31'd0, div_done}, 32'd0);
        end
        @(negedge clk);
        #1;
        chk("div_end_stall", {28'd0, stall}, 32'd0);
        chk("div_end_done", {31'd0, div_done}, 32'd1);
        chk("div_end_busy", {31'd0, div_busy}, 32'd1);
        @(negedge clk);
        #1;
        chk("div_after_busy", {31'd0, div_busy}, 32'd0);
        chk("div_after_done", {31'd0, div_done}, 32'd0);

        // Divide with a 3-cycle MEM stall in the middle: done moves to cycle 35
        @(negedge clk);
        ex_div_start = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            ex_div_start = 1'b0;
            mem_k = (k >= 11) && (k <= 13);
            mem_stall_req = mem_k;
            #1;
            if (k == 35) exp_stall = 4'b0000;
            else if (mem_k) exp_stall = 4'b1111;
            else exp_stall = 4'b0111;
            chk("divmem_stall", {28'd0, stall}, {28'd0, exp_stall});
            chk("divmem_done", {31'd0, div_done}, {31'd0, (k == 35)});
        end
        @(negedge clk);
        #1;
        chk("divmem_after_busy", {31'd0, div_busy}, 32'd0);

        // Exception aborts a divide; start and stall requests ignored in FLUSH
        @(negedge clk);
        ex_div_start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            ex_div_start = 1'b0;
            exc_valid = (k == 5);
            #1;
            chk("exc_div_busy", {31'd0, div_busy}, 32'd1);
            chk("exc_div_done", {31'd0, div_done}, 32'd0);
        end
        @(negedge clk);
        exc_valid = 1'b0;
        mem_stall_req = 1'b1;
        ex_div_start = 1'b1;
        #1;
        chk("exc_flush", {31'd0, flush}, 32'd1);
        chk("exc_new_pc", new_pc, 32'hBFC00380);
        chk("exc_stall", {28'd0, stall}, 32'd0);
        chk("exc_done", {31'd0, div_done}, 32'd0);
        chk("exc_busy", {31'd0, div_busy}, 32'd0);
        @(negedge clk);
        mem_stall_req = 1'b0;
        ex_div_start = 1'b0;
        #1;
        chk("exc_post_flush", {31'd0, flush}, 32'd0);
        chk("exc_post_busy", {31'd0, div_busy}, 32'd0);

        // ERET accepted under a MEM stall; flush beats stall next cycle
        @(negedge clk);
        exc_valid = 1'b1;
        exc_eret = 1'b1;
        cp0_epc = 32'h8000_1234;
        mem_stall_req = 1'b1;
        #1;
        chk("eret_pre_stall", {28'd0, stall}, 32'hF);
        chk("eret_pre_flush", {31'd0, flush}, 32'd0);
        @(negedge clk);
        exc_valid = 1'b0;
        exc_eret = 1'b0;
        cp0_epc = 32'hDEAD_BEEF;
        #1;
        chk("eret_flush", {31'd0, flush}, 32'd1);
        chk("eret_new_pc", new_pc, 32'h8000_1234);
        chk("eret_stall", {28'd0, stall}, 32'd0);
        @(negedge clk);
        mem_stall_req = 1'b0;
        #1;
        chk("eret_post_flush", {31'd0, flush}, 32'd0);
        chk("eret_post_stall", {28'd0, stall}, 32'd0);

        // Exception beats a simultaneous divide start
        @(negedge clk);
        ex_div_start = 1'b1;
        exc_valid = 1'b1;
        #1;
        @(negedge clk);
        ex_div_start = 1'b0;
        exc_valid = 1'b0;
        #1;
        chk("excdiv_flush", {31'd0, flush}, 32'd1);
        chk("excdiv_new_pc", new_pc, 32'hBFC00380);
        chk("excdiv_busy", {31'd0, div_busy}, 32'd0);
        @(negedge clk);
        #1;
        chk("excdiv_post_busy", {31'd0, div_busy}, 32'd0);
        chk("excdiv_post_flush", {31'd0, flush}, 32'd0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        ex_div_start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            ex_div_start = 1'b0;
        end
        #1;
        chk("rstdiv_pre_busy", {31'd0, div_busy}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rstdiv_busy", {31'd0, div_busy}, 32'd0);
        chk("rstdiv_done", {31'd0, div_done}, 32'd0);
        chk("rstdiv_stall", {28'd0, stall}, 32'd0);
        chk("rstdiv_new_pc", new_pc, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstdiv_rel_busy", {31'd0, div_busy}, 32'd0);

        // ID and IF requests together for 5 cycles
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            id_stall_req = 1'b1;
            if_stall_req = 1'b1;
            #1;
            chk("idif_stall", {28'd0, stall}, 32'h3);
        end
        @(negedge clk);
        id_stall_req = 1'b0;
        if_stall_req = 1'b1;
        #1;
`ifdef PIPE_PERF_CNT_EN
        exp_perf = 32'd5;
`else
        exp_perf = 32'd0;
`endif
        chk("perf_5", stall_cycles, exp_perf);
        chk("if_only_stall", {28'd0, stall}, 32'h1);
        @(negedge clk);
        if_stall_req = 1'b0;
        #1;
`ifdef PIPE_PERF_CNT_EN
        exp_perf = 32'd6;
`else
        exp_perf = 32'd0;
`endif
        chk("perf_6", stall_cycles, exp_perf);
        chk("final_stall", {28'd0, stall}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
